// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl
//   Stream-side controller for a 3x3 signed 8-bit matrix multiplier.
//   Collects 18 elements (A row-major, then B row-major) from a byte
//   stream, packs them onto the multiplier operand buses, pulses the
//   multiplier reset, holds its enable until done (or a timeout), then
//   plays the nine result elements back out row-major on a byte stream.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   in_data_i      input element (two's complement)
//   in_valid_i     in_data_i valid
//   in_ready_o     controller accepts in_data_i (LOAD only)
//   out_data_o     result element, row-major
//   out_valid_o    out_data_o valid (SEND only)
//   out_ready_i    downstream accepts out_data_o
//   mul_a_o        operand A, element (i,j) at [(i*3+j)*8 +: 8]
//   mul_b_o        operand B, same packing
//   mul_reset_o    one-cycle multiplier reset pulse
//   mul_enable_o   multiplier enable, high for the whole RUN phase
//   mul_c_i        multiplier result, same packing
//   mul_done_i     multiplier result valid
//   busy_o         high in every state except LOAD
//   err_o          sticky timeout flag, cleared by the next load
module matrix_stream_ctrl #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [71:0] mul_a_o,
    output logic [71:0] mul_b_o,
    output logic        mul_reset_o,
    output logic        mul_enable_o,
    input  logic [71:0] mul_c_i,
    input  logic        mul_done_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_LOAD, S_CLR, S_RUN, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;     // element index, shared by LOAD and SEND
    logic [TW-1:0]   tmo_q, tmo_d;     // RUN cycles elapsed
    logic            err_q, err_d;
    logic [71:0]     res_q, res_d;
    logic            in_accept;
    logic            out_accept;

    assign in_accept  = (state_q == S_LOAD) && in_valid_i;
    assign out_accept = (state_q == S_SEND) && out_ready_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        res_d   = res_q;
        case (state_q)
            S_LOAD: begin
                if (in_accept) begin
                    // err survives until the next load actually starts
                    if (idx_q == 5'd0) err_d = 1'b0;
                    if (idx_q == 5'd17) begin
                        idx_d   = '0;
                        state_d = S_CLR;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_CLR: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                tmo_d = tmo_q + 1'b1;
                // done wins even on the cycle the counter expires
                if (mul_done_i) begin
                    res_d   = mul_c_i;
                    state_d = S_SEND;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_SEND: begin
                if (out_accept) begin
                    if (idx_q == 5'd8) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o   = 1'b0;
        mul_reset_o  = 1'b0;
        mul_enable_o = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;
        out_data_o   = '0;
        case (state_q)
            S_LOAD: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            S_CLR:  mul_reset_o  = 1'b1;
            S_RUN:  mul_enable_o = 1'b1;
            S_SEND: begin
                out_valid_o = 1'b1;
                out_data_o  = res_q[{idx_q, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Operand slots: slot gi of A takes load index gi, slot gi of B takes
    // load index gi+9. Slots keep their value until the next load rewrites.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 9; gi++) begin : g_slot
        logic [7:0] a_q;
        logic [7:0] b_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_q <= '0;
                b_q <= '0;
            end else if (in_accept) begin
                if (idx_q == 5'(gi))     a_q <= in_data_i;
                if (idx_q == 5'(gi + 9)) b_q <= in_data_i;
            end
        end

        assign mul_a_o[gi*8 +: 8] = a_q;
        assign mul_b_o[gi*8 +: 8] = b_q;
    end

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
module tb_matrix_stream_ctrl;

    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [71:0] mul_a_o, mul_b_o;
    logic        mul_reset_o, mul_enable_o;
    logic [71:0] mul_c_i;
    logic        mul_done_i;
    logic        busy_o, err_o;

    int errors = 0;
    int checks = 0;

    // multiplier model knobs
    int lat  = 1;
    bit hang = 1'b0;
    int mcnt = 0;

    always #5 clk = ~clk;

    matrix_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_reset_o(mul_reset_o), .mul_enable_o(mul_enable_o),
        .mul_c_i(mul_c_i), .mul_done_i(mul_done_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Reference 3x3 signed product, wrapped to 8 bits per element.
    function automatic logic [71:0] mat_mul(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) begin
                    logic signed [7:0] x, y;
                    x = a[(i*3+k)*8 +: 8];
                    y = b[(k*3+j)*8 +: 8];
                    s += int'(x) * int'(y);
                end
                r[(i*3+j)*8 +: 8] = 8'(s);
            end
        return r;
    endfunction

    // Behavioural multiplier: done after 'lat' enabled cycles, junk on mul_c otherwise.
    always @(negedge clk) begin
        if (rst_i || mul_reset_o) begin
            mcnt = 0;
            mul_done_i = 1'b0;
            mul_c_i = 72'({$urandom, $urandom, $urandom});
        end else if (mul_enable_o) begin
            mcnt++;
            if (!hang && mcnt >= lat) begin
                mul_done_i = 1'b1;
                mul_c_i = mat_mul(mul_a_o, mul_b_o);
            end else begin
                mul_done_i = 1'b0;
                mul_c_i = 72'({$urandom, $urandom, $urandom});
            end
        end else begin
            mul_done_i = 1'b0;
            mul_c_i = 72'({$urandom, $urandom, $urandom});
        end
    end

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [71:0] diag(input logic [7:0] v);
        logic [71:0] r = '0;
        r[0 +: 8] = v; r[32 +: 8] = v; r[64 +: 8] = v;
        return r;
    endfunction

    function automatic logic [71:0] ramp(input bit neg);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = neg ? 8'(-(k+1)) : 8'(k+1);
        return r;
    endfunction

    function automatic logic [71:0] rnd72();
        return 72'({$urandom, $urandom, $urandom});
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Offer one element; returns at the negedge after it was accepted.
    task automatic send_elem(input logic [7:0] d);
        bit ok = 1'b0;
        bit r;
        in_valid_i = 1'b1;
        in_data_i  = d;
        for (int n = 0; n < 50; n++) begin
            r = in_ready_o;
            @(posedge clk);
            if (r) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic load_range(input logic [71:0] a, input logic [71:0] b,
                              input int from, input int to, input bit gaps);
        for (int k = from; k <= to; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_elem(k < 9 ? a[k*8 +: 8] : b[(k-9)*8 +: 8]);
        end
    endtask

    // Called at the negedge of the CLR cycle; runs until the block is idle again.
    // mode 0: ready high, 1: random ready, 2: 5-cycle stall on element index 2.
    task automatic collect(input int mode, output logic [71:0] got, output int n,
                           output int first, output int done,
                           output bit clr_ok, output bit run_ok);
        int stalls = 0;
        bit prev_hold = 1'b0;
        bit rdy;
        logic [7:0] prev_data = '0;
        got = '0; n = 0; first = 0; done = 0; clr_ok = 1'b0; run_ok = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1 && !busy_o) begin done = c; break; end
            if (c == 1) clr_ok = mul_reset_o && !in_ready_o && busy_o && !mul_enable_o;
            if (c == 2) run_ok = mul_enable_o && !mul_reset_o && !in_ready_o;
            if (out_valid_o) begin
                if (first == 0) first = c;
                if (prev_hold) chk("hold_stable", 72'(out_data_o), 72'(prev_data));
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = !(n == 2 && stalls < 5);
                endcase
                if (!rdy) stalls++;
                out_ready_i = rdy;
                prev_hold = !rdy;
                prev_data = out_data_o;
                if (rdy) begin
                    if (n < 9) got[n*8 +: 8] = out_data_o;
                    n++;
                end
            end else begin
                out_ready_i = 1'($urandom_range(0, 1));
                prev_hold = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
    endtask

    typedef struct {
        logic [71:0] a;
        logic [71:0] b;
        logic [71:0] exp;
        int          lat;
        int          mode;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] a, b, got, exp;
        int n, first, done;
        bit clr_ok, run_ok;

        vecs[0] = '{a: diag(8'h01), b: ramp(1'b0), exp: ramp(1'b0), lat: 1, mode: 0};
        vecs[1] = '{a: fill(8'h02), b: fill(8'h03), exp: fill(8'h12), lat: 3, mode: 0};
        vecs[2] = '{a: fill(8'h10), b: fill(8'h10), exp: fill(8'h00), lat: 2, mode: 0};
        vecs[3] = '{a: diag(8'hFF), b: ramp(1'b0), exp: ramp(1'b1), lat: 4, mode: 2};

        rst_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
        mul_done_i = 1'b0; mul_c_i = '0;
        #1 rst_i = 1'b1;
        #2;
        chk("rst_in_ready",  72'(in_ready_o), 72'(1));
        chk("rst_out_valid", 72'(out_valid_o), 72'(0));
        chk("rst_out_data",  72'(out_data_o), 72'(0));
        chk("rst_mul_a",     mul_a_o, 72'(0));
        chk("rst_mul_b",     mul_b_o, 72'(0));
        chk("rst_ctrl",      72'({mul_reset_o, mul_enable_o, busy_o, err_o}), 72'(0));
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i < 4; i++) begin
            lat = vecs[i].lat; hang = 1'b0;
            load_range(vecs[i].a, vecs[i].b, 0, 17, 1'b0);
            collect(vecs[i].mode, got, n, first, done, clr_ok, run_ok);
            chk($sformatf("v%0d_count", i), 72'(n), 72'(9));
            for (int k = 0; k < 9; k++)
                chk($sformatf("v%0d_e%0d", i, k), 72'(got[k*8 +: 8]), 72'(vecs[i].exp[k*8 +: 8]));
            chk($sformatf("v%0d_clr", i), 72'(clr_ok), 72'(1));
            chk($sformatf("v%0d_run", i), 72'(run_ok), 72'(1));
            chk($sformatf("v%0d_first", i), 72'(first), 72'(vecs[i].lat + 2));
            chk($sformatf("v%0d_idle", i), 72'(done),
                72'(vecs[i].lat + (vecs[i].mode == 2 ? 16 : 11)));
            chk($sformatf("v%0d_in_ready", i), 72'(in_ready_o), 72'(1));
            chk($sformatf("v%0d_hold_a", i), mul_a_o, vecs[i].a);
            chk($sformatf("v%0d_hold_b", i), mul_b_o, vecs[i].b);
            $display("txn vec%0d: lat=%0d mode=%0d outputs=%0d result=%h", i, lat, vecs[i].mode, n, got);
        end

        // ---------------- timeout and recovery ----------------
        hang = 1'b1;
        a = rnd72(); b = rnd72();
        load_range(a, b, 0, 17, 1'b1);
        collect(0, got, n, first, done, clr_ok, run_ok);
        chk("tmo_no_output", 72'(n), 72'(0));
        chk("tmo_no_valid", 72'(first), 72'(0));
        chk("tmo_idle_cycle", 72'(done), 72'(TIMEOUT + 2));
        chk("tmo_err", 72'(err_o), 72'(1));
        chk("tmo_in_ready", 72'(in_ready_o), 72'(1));
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", 72'(err_o), 72'(1));
        $display("txn timeout: idle_at=%0d err=%0b", done, err_o);

        hang = 1'b0; lat = 2;
        a = rnd72(); b = rnd72();
        load_range(a, b, 0, 0, 1'b0);
        chk("tmo_err_cleared", 72'(err_o), 72'(0));
        load_range(a, b, 1, 17, 1'b0);
        collect(0, got, n, first, done, clr_ok, run_ok);
        exp = mat_mul(a, b);
        chk("recov_count", 72'(n), 72'(9));
        chk("recov_result", got, exp);
        $display("txn recovery: outputs=%0d result=%h", n, got);

        // ---------------- done on the last allowed RUN cycle ----------------
        lat = TIMEOUT;
        a = rnd72(); b = rnd72();
        load_range(a, b, 0, 17, 1'b0);
        collect(0, got, n, first, done, clr_ok, run_ok);
        chk("prio_count", 72'(n), 72'(9));
        chk("prio_result", got, mat_mul(a, b));
        chk("prio_err", 72'(err_o), 72'(0));
        chk("prio_first", 72'(first), 72'(TIMEOUT + 2));
        $display("txn priority: outputs=%0d first=%0d", n, first);

        // ---------------- randomized transactions vs. model ----------------
        for (int t = 0; t < 8; t++) begin
            lat = $urandom_range(1, 10);
            a = rnd72(); b = rnd72();
            load_range(a, b, 0, 17, 1'b1);
            collect(1, got, n, first, done, clr_ok, run_ok);
            chk($sformatf("rnd%0d_count", t), 72'(n), 72'(9));
            chk($sformatf("rnd%0d_result", t), got, mat_mul(a, b));
            chk($sformatf("rnd%0d_first", t), 72'(first), 72'(lat + 2));
            $display("txn rnd%0d: lat=%0d outputs=%0d result=%h", t, lat, n, got);
        end

        // ---------------- reset mid-load ----------------
        lat = 2;
        a = rnd72() | 72'h1; b = rnd72() | 72'h1;
        load_range(a, b, 0, 9, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("rstload_in_ready", 72'(in_ready_o), 72'(1));
        chk("rstload_busy", 72'(busy_o), 72'(0));
        chk("rstload_mul_a", mul_a_o, 72'(0));
        chk("rstload_mul_b", mul_b_o, 72'(0));
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        $display("txn reset_mid_load: busy=%0b", busy_o);

        // ---------------- reset during SEND element 4 ----------------
        a = rnd72(); b = rnd72();
        exp = mat_mul(a, b);
        load_range(a, b, 0, 17, 1'b0);
        n = 0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid_o && n == 3) break;
            if (out_valid_o) n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstsend_reached", 72'(out_valid_o), 72'(1));
        chk("rstsend_elem3", 72'(out_data_o), 72'(exp[24 +: 8]));
        #2 rst_i = 1'b1;
        #1;
        chk("rstsend_valid", 72'(out_valid_o), 72'(0));
        chk("rstsend_data", 72'(out_data_o), 72'(0));
        chk("rstsend_busy", 72'(busy_o), 72'(0));
        chk("rstsend_in_ready", 72'(in_ready_o), 72'(1));
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        $display("txn reset_mid_send: out_valid=%0b", out_valid_o);

        a = rnd72(); b = rnd72();
        load_range(a, b, 0, 17, 1'b1);
        collect(1, got, n, first, done, clr_ok, run_ok);
        chk("postrst_count", 72'(n), 72'(9));
        chk("postrst_result", got, mat_mul(a, b));
        $display("txn post_reset: outputs=%0d result=%h", n, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
